// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner: scan FSM states, the
// candidate-key record (valid bit beside the code) and the 4x4 hex legend.
package keypad_pkg;

    typedef enum logic [1:0] {
        DRIVE,
        WAIT,
        SAMPLE,
        HOLD
    } scan_state_t;

    // Wide enough for the largest 8x8 matrix
    localparam int MAX_CODE_W = 6;

    typedef struct packed {
        logic                  valid;
        logic [MAX_CODE_W-1:0] code;
    } key_cand_t;

    localparam key_cand_t KEY_NONE = '{valid: 1'b0, code: '0};

    // Row-major legend of the standard 4x4 hex keypad
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    function automatic logic [3:0] map_key(input logic [3:0] idx);
        return KEY_MAP[idx];
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Show-ahead event queue; push while full is accepted only if a pop frees
// the head slot in the same cycle, pop while empty is ignored.
module keypad_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CNW = AW + 1;
    localparam logic [CNW-1:0] FULL_COUNT = CNW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNW-1:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == FULL_COUNT);
    assign valid     = (r_count != '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && valid;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-cold column drive, debounced full-scan decode, event FIFO.
// Build option KEYPAD_HEX_MAP_EN translates 4x4 key positions through KEY_MAP.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 4,
    parameter int COL_PERIOD     = 100000,
    parameter int SETTLE         = 8,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4,
    localparam int CW            = $clog2(NUM_ROWS * NUM_COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [CW-1:0]       key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_held,
    output logic                ghost,
    output logic                overflow
);
    // state  | meaning
    // DRIVE  | slot 0, column just driven low
    // WAIT   | rows settling through the synchronizer
    // SAMPLE | slot SETTLE, capture rows into snapshot column
    // HOLD   | idle until the slot ends, then next column
    localparam int CNT_W = $clog2(COL_PERIOD);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(COL_PERIOD - 1);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(NUM_COLS - 1);
    localparam logic [3:0]       DB_TARGET   = 4'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0]   r_row_s1;
    logic [NUM_ROWS-1:0]   r_row_s2;
    scan_state_t           r_state;
    scan_state_t           w_state_next;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_next;
    logic [COL_W-1:0]      r_col_idx;
    logic [COL_W-1:0]      w_col_next;
    logic                  r_run;
    logic                  w_sample;
    logic [NUM_ROWS-1:0]   r_snap [NUM_COLS];
    logic                  r_eval;
    key_cand_t             r_cand;
    key_cand_t             r_stable;
    key_cand_t             w_cand;
    logic [3:0]            r_match;
    logic [3:0]            w_match_next;
    logic                  w_seen;
    logic                  w_many;
    logic [MAX_CODE_W-1:0] w_idx;
    logic                  w_accept;
    logic                  w_change;
    logic                  w_push;
    logic [CW-1:0]         w_push_code;
    logic                  w_fifo_full;
    logic                  r_ghost;
    logic                  r_held;
    logic                  r_overflow;

`ifdef KEYPAD_HEX_MAP_EN
    if (NUM_ROWS != 4 || NUM_COLS != 4) begin : g_map_size_err
        $error("KEYPAD_HEX_MAP_EN requires a 4x4 matrix");
    end
    assign w_push_code = CW'(map_key(w_cand.code[3:0]));
`else
    assign w_push_code = w_cand.code[CW-1:0];
`endif

    // Columns float high until the first post-reset cycle starts column 0
    assign col      = r_run ? ~(NUM_COLS'(1) << r_col_idx) : '1;
    assign key_held = r_held;
    assign ghost    = r_ghost;
    assign overflow = r_overflow;

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count + 1'b1;
        w_col_next   = r_col_idx;
        w_sample     = 1'b0;
        case (r_state)
            DRIVE:  w_state_next = WAIT;
            WAIT:   if (r_count == SETTLE_LAST) w_state_next = SAMPLE;
            SAMPLE: begin
                w_sample     = 1'b1;
                w_state_next = HOLD;
            end
            HOLD: if (r_count == SLOT_LAST) begin
                w_state_next = DRIVE;
                w_count_next = '0;
                w_col_next   = (r_col_idx == COL_LAST) ? '0 : r_col_idx + 1'b1;
            end
            default: w_state_next = DRIVE;
        endcase
    end

    always_comb begin
        w_seen = 1'b0;
        w_many = 1'b0;
        w_idx  = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (r_snap[c][r]) begin
                    w_many = w_many | w_seen;
                    w_seen = 1'b1;
                    w_idx  = MAX_CODE_W'(r * NUM_COLS + c);
                end
            end
        end
        // A ghost scan repeats the previous candidate
        w_cand = r_cand;
        if (!w_many) begin
            w_cand.valid = w_seen;
            w_cand.code  = w_idx;
        end
        if (w_cand == r_cand)
            w_match_next = (r_match >= DB_TARGET) ? DB_TARGET : r_match + 1'b1;
        else
            w_match_next = 4'd1;
        w_accept = (w_match_next == DB_TARGET);
        w_change = w_accept && (w_cand != r_stable);
        w_push   = r_eval && w_change && w_cand.valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DRIVE;
            r_count   <= '0;
            r_col_idx <= '0;
            r_run     <= 1'b0;
            r_row_s1  <= '1;
            r_row_s2  <= '1;
            r_eval    <= 1'b0;
            for (int c = 0; c < NUM_COLS; c++) r_snap[c] <= '0;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
            r_run    <= 1'b1;
            if (r_run) begin
                r_state   <= w_state_next;
                r_count   <= w_count_next;
                r_col_idx <= w_col_next;
            end
            if (w_sample) r_snap[r_col_idx] <= ~r_row_s2;
            r_eval <= w_sample && (r_col_idx == COL_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand     <= KEY_NONE;
            r_stable   <= KEY_NONE;
            r_match    <= '0;
            r_ghost    <= 1'b0;
            r_held     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (r_eval) begin
                r_cand  <= w_cand;
                r_match <= w_match_next;
                r_ghost <= w_many;
                if (w_accept) r_stable <= w_cand;
                if (w_change) r_held <= w_cand.valid;
            end
            if (w_push && w_fifo_full && !(key_valid && key_ready)) r_overflow <= 1'b1;
        end
    end

    keypad_event_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_push_code),
        .full  (w_fifo_full),
        .pop   (key_ready),
        .valid (key_valid),
        .head  (key_code)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner on a 4x4 matrix with a 64-cycle scan;
// expected key codes follow the raw index, or the hex legend under KEYPAD_HEX_MAP_EN.
module tb_keypad_scanner;
    localparam int NR = 4;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b1;
    logic        key_held;
    logic        ghost;
    logic        overflow;
    logic [15:0] keys = '0;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_extra  = 0;
    logic [3:0] sb [$];

    always #5 clk = ~clk;

    // Passive switch matrix: a pressed key shorts its row to a driven column
    always_comb begin
        row = '1;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (keys[r*NC+c] && !col[c]) row[r] = 1'b0;
    end

    keypad_scanner #(
        .NUM_ROWS       (NR),
        .NUM_COLS       (NC),
        .COL_PERIOD     (16),
        .SETTLE         (3),
        .DEBOUNCE_SCANS (2),
        .FIFO_DEPTH     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .ghost     (ghost),
        .overflow  (overflow)
    );

    function automatic logic [3:0] exp_code(input int r, input int c);
`ifdef KEYPAD_HEX_MAP_EN
        logic [63:0] legend;
        legend = 64'h123A_456B_789C_0FED;
        return legend[63-4*(r*NC+c) -: 4];
`else
        return 4'(r*NC + c);
`endif
    endfunction

    function automatic logic [15:0] kbit(input int r, input int c);
        return 16'(1) << (r*NC + c);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the start of column 0, n times; returns at posedge+#1 of that cycle
    task automatic wait_scans(input int n);
        logic [3:0] prev;
        int         cyc;
        bit         timed_out;
        for (int k = 0; k < n; k++) begin
            cyc       = 0;
            timed_out = 1'b0;
            prev      = col;
            forever begin
                @(posedge clk); #1;
                cyc++;
                if (col == 4'b1110 && prev != 4'b1110) break;
                prev = col;
                if (cyc > 200) begin
                    timed_out = 1'b1;
                    break;
                end
            end
            check("scan_wait_timeout", 32'(timed_out), 32'd0);
        end
    endtask

    // Consumer side: a transfer happens at the next posedge
    initial begin
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1 && key_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_extra++;
                    $display("FAIL extra_event: got code %0h expected no event at %0t", key_code, $time);
                end else begin
                    check("key_code", 32'(key_code), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] ecol;
        int         cyc;

        // Reset and scan order
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", 32'(col), 32'hF);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        check("rst_ghost", 32'(ghost), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        cyc = 0;
        while (col == 4'b1111 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("first_col", 32'(col), 32'hE);
        for (int k = 1; k < NC; k++) begin
            repeat (16) @(posedge clk);
            #1;
            ecol = ~(4'b0001 << k);
            check("col_step", 32'(col), 32'(ecol));
        end
        wait_scans(2);
        check("idle_valid", 32'(key_valid), 32'd0);
        check("idle_held", 32'(key_held), 32'd0);
        check("idle_ghost", 32'(ghost), 32'd0);

        // Single press then release
        keys = kbit(1, 2);
        sb.push_back(exp_code(1, 2));
        wait_scans(3);
        check("press_held", 32'(key_held), 32'd1);
        check("press_sb_drained", 32'(sb.size()), 32'd0);
        keys = '0;
        wait_scans(2);
        check("release_held", 32'(key_held), 32'd0);

        // Bounce: one scan present, one absent, then two present
        keys = kbit(3, 1);
        wait_scans(1);
        keys = '0;
        wait_scans(1);
        check("bounce_no_held", 32'(key_held), 32'd0);
        keys = kbit(3, 1);
        sb.push_back(exp_code(3, 1));
        wait_scans(2);
        check("bounce_held", 32'(key_held), 32'd1);
        check("bounce_sb_drained", 32'(sb.size()), 32'd0);
        keys = '0;
        wait_scans(2);

        // Ghost: two keys together, then one released
        keys = kbit(0, 0) | kbit(2, 3);
        wait_scans(3);
        check("ghost_set", 32'(ghost), 32'd1);
        check("ghost_no_held", 32'(key_held), 32'd0);
        check("ghost_no_event", 32'(key_valid), 32'd0);
        keys = kbit(0, 0);
        sb.push_back(exp_code(0, 0));
        wait_scans(1);
        check("ghost_cleared", 32'(ghost), 32'd0);
        wait_scans(1);
        check("ghost_release_held", 32'(key_held), 32'd1);
        check("ghost_sb_drained", 32'(sb.size()), 32'd0);
        keys = '0;
        wait_scans(2);
        check("ghost_end_held", 32'(key_held), 32'd0);

        // Backpressure and overflow on a two-entry queue
        key_ready = 1'b0;
        keys = kbit(1, 1);
        sb.push_back(exp_code(1, 1));
        wait_scans(2);
        check("bp_valid", 32'(key_valid), 32'd1);
        check("bp_head", 32'(key_code), 32'(exp_code(1, 1)));
        check("bp_no_overflow", 32'(overflow), 32'd0);
        keys = kbit(2, 2);
        sb.push_back(exp_code(2, 2));
        wait_scans(2);
        keys = kbit(3, 3);
        wait_scans(2);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_valid", 32'(key_valid), 32'd1);
        check("ovf_head_kept", 32'(key_code), 32'(exp_code(1, 1)));
        keys = '0;
        wait_scans(2);
        key_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_valid", 32'(key_valid), 32'd0);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of column 2 with a queued event
        key_ready = 1'b0;
        keys = kbit(0, 1);
        wait_scans(2);
        check("pre_rst_valid", 32'(key_valid), 32'd1);
        check("pre_rst_held", 32'(key_held), 32'd1);
        keys = '0;
        cyc  = 0;
        ecol = col;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if ((col == 4'b1011 && ecol != 4'b1011) || cyc > 200) break;
            ecol = col;
        end
        check("col2_found", 32'(col), 32'hB);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_col", 32'(col), 32'hF);
        check("mid_rst_valid", 32'(key_valid), 32'd0);
        check("mid_rst_held", 32'(key_held), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        key_ready = 1'b1;
        cyc = 0;
        while (col == 4'b1111 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("restart_col", 32'(col), 32'hE);
        check("restart_latency", 32'(cyc), 32'd1);
        wait_scans(2);
        check("post_rst_valid", 32'(key_valid), 32'd0);
        check("post_rst_held", 32'(key_held), 32'd0);

        check("extra_events", 32'(n_extra), 32'd0);
        check("sb_final_empty", 32'(sb.size()), 32'd0);
        if (n_extra != 0) n_fail += n_extra;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner: drives one column low at a time, samples rows, debounces across full scans and queues key-press events.
- Generalises the fixed 4x4 decoder to NUM_ROWS x NUM_COLS, adds ghost rejection, press/hold tracking and a valid/ready event FIFO.
- Sits between keypad pins and game/control logic in the same clock domain.

Parameters:
- NUM_ROWS, 4, row lines (2..8)
- NUM_COLS, 4, column lines (2..8)
- COL_PERIOD, 100000, cycles each column stays driven; must be greater than SETTLE+1
- SETTLE, 8, cycles from column drive to row sample; must be at least 3
- DEBOUNCE_SCANS, 3, consecutive identical full scans before a result is accepted (1..15)
- FIFO_DEPTH, 4, event queue entries (power of 2, at least 2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- row  in  NUM_ROWS  active-low row sense; asynchronous pins
- col  out  NUM_COLS  active-low column drive, one-cold
- key_code  out  CW=$clog2(NUM_ROWS*NUM_COLS)  head-of-queue key code
- key_valid  out  1  queue non-empty
- key_ready  in  1  consumer accepts head on key_valid && key_ready
- key_held  out  1  a debounced key is currently down
- ghost  out  1  last full scan saw more than one key
- overflow  out  1  sticky: an event was dropped on a full queue

Behaviour:
- Reset values: col all ones, key_code 0, key_valid 0, key_held 0, ghost 0, overflow 0. All counters, the snapshot, the debounce history and the FIFO are cleared. Reset mid-scan restarts at column 0 on the first cycle after rst deasserts.
- row passes through a 2-flop synchronizer. SETTLE covers this delay.
- Slot counter runs 0..COL_PERIOD-1 for each column c = 0..NUM_COLS-1, then wraps to column 0.
- FSM states:
  - DRIVE: slot count 0; col[c] is driven 0.
  - WAIT: until count == SETTLE.
  - SAMPLE: one cycle; captures the synchronized row bits into snapshot column c.
  - HOLD: until count == COL_PERIOD-1, then moves to the next column.
- Full-scan evaluation runs one cycle after the SAMPLE of column NUM_COLS-1:
  - 0 keys low → candidate NONE.
  - Exactly 1 key low at (r,c) → candidate code r*NUM_COLS+c.
  - More than 1 key low → ghost=1, candidate unchanged from previous scan. ghost clears on the next scan that is not a ghost.
- Debounce: a candidate equal to the previous scan's candidate increments the match count, which saturates at DEBOUNCE_SCANS. Any other candidate sets the count to 1. The candidate is accepted as stable when the count reaches DEBOUNCE_SCANS.
- Stable-state change handling:
  - NONE→K, or K1→K2 with K1≠K2: push K into the FIFO and set key_held=1.
  - K→NONE: key_held=0, no push.
  - Same stable key held: no further pushes (no auto-repeat).
- Latency: push is registered in the evaluation cycle; key_valid is high the next cycle, i.e. 2 cycles after the final SAMPLE.
- FIFO:
  - Show-ahead: key_code is valid whenever key_valid=1 and holds the head value while key_ready=0.
  - Pop on key_valid && key_ready.
  - Push and pop in the same cycle are allowed at any fill level, including full; count is unchanged.
  - Push on full without a pop: the new event is dropped and overflow is set; it clears only on rst.
  - Pop on empty is ignored.

Optional Feature:
- Macro: KEYPAD_HEX_MAP_EN. Requires NUM_ROWS=NUM_COLS=4 (elaboration error otherwise).
- Defined: the pushed code is translated through the package constant KEY_MAP, row-major layout:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: 0,F,E,D
- Undefined: the raw index r*NUM_COLS+c is pushed.

Decomposition:
- Package keypad_pkg holds:
  - scan_state_t enum (DRIVE, WAIT, SAMPLE, HOLD)
  - KEY_MAP[16] constant
  - NONE sentinel encoding: an internal valid bit beside the code
- Sub-module keypad_event_fifo (parameters WIDTH and DEPTH; push, full, pop, valid, head) is instantiated once.

Test Plan:
Common parameters: NUM_ROWS=NUM_COLS=4, COL_PERIOD=16, SETTLE=3, DEBOUNCE_SCANS=2, FIFO_DEPTH=2 (64-cycle scan).
- Reset and scan: hold rst for 3 cycles with all rows high → col steps 1110, 1101, 1011, 0111 every 16 cycles. key_valid, key_held, ghost and overflow stay 0.
- Single press: (r=1, c=2) low for 3 scans → exactly one event with key_code 6 (raw and mapped) and key_held=1. Release for 2 scans → key_held=0 and no second event.
- Bounce: (r=3, c=1) present for 1 scan, absent for 1, present for 2 → exactly one event, raw 13, or 0xF with KEYPAD_HEX_MAP_EN.
- Ghost: (0,0) and (2,3) pressed together for 3 scans → ghost=1 and no event. Releasing (2,3) → event with code 0 after 2 scans, and ghost clears.
- Backpressure and overflow: key_ready=0; press keys 5, 10 and 15 in sequence, each held 2 scans → key_valid=1 and overflow=1. Draining yields 5 then 10; key_valid then drops.
- Reset mid-scan: assert rst at count 7 of column 2 → next cycle col=1111 and FIFO empty; after release, scanning restarts at column 0.
